// File: rtl/lpt_fetch_if.sv
// lpt_fetch_if: read-only video RAM port used by the LPT fetcher.
// ram_a is the read address; ram_q is the registered read data (1-cycle latency).
interface lpt_fetch_if #(
    parameter int AW = 16
);
    logic [AW-1:0] ram_a;
    logic [7:0]    ram_q;

    modport master (output ram_a, input ram_q);
    modport slave  (input ram_a, output ram_q);
endinterface

// File: rtl/lpt_fetch.sv
// lpt_fetch: walks the line parameter table in video RAM, one 16-byte line
// parameter block per req, and presents the decoded fields.
// Build option LPT_SHADOW_EN: bytes go to a shadow set and all fields are
// published together with done; otherwise each field byte updates as it lands.
//
// state | meaning
// IDLE  | waiting for req; restart reloads ptr immediately
// FETCH | issuing addresses ptr+0 .. ptr+15
// DRAIN | collecting the last two bytes still in the RAM pipeline
module lpt_fetch #(
    parameter int AW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] lpt_base,
    input  logic          restart,
    input  logic          req,
    lpt_fetch_if.master   ram,
    output logic          busy,
    output logic          done,
    output logic [7:0]    lines,
    output logic [7:0]    mode,
    output logic [7:0]    lmargin,
    output logic [7:0]    rmargin,
    output logic [15:0]   ld1,
    output logic [15:0]   ld2,
    output logic [63:0]   palette
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t        state, state_nx;
    logic [4:0]    cnt;
    logic [AW-1:0] ptr;
    logic [AW-1:0] addr;
    logic          restart_pend;
    logic [7:0]    fld [16];
    logic [AW-1:0] base_al;
    logic [4:0]    cap_off;
    logic [3:0]    cap_idx;
    logic          cap_en;
    logic          reload_flag;
    logic          unused_base;

`ifdef LPT_SHADOW_EN
    logic [7:0]    shd [16];
    assign reload_flag = shd[1][0];
`else
    assign reload_flag = fld[1][0];
`endif

    assign base_al     = {lpt_base[AW-1:4], 4'h0};
    assign unused_base = ^lpt_base[3:0];
    // cnt equals n right before edge En, so byte n-2 is on ram_q at that edge
    assign cap_off     = cnt - 5'd2;
    assign cap_idx     = cap_off[3:0];
    assign cap_en      = (state != IDLE) && (cnt >= 5'd2);

    assign ram.ram_a = addr;
    // done's cycle still counts as busy even though the FSM is already idle
    assign busy      = (state != IDLE) || done;

    assign lines   = fld[0];
    assign mode    = fld[1];
    assign lmargin = fld[2];
    assign rmargin = fld[3];
    assign ld1     = {fld[5], fld[4]};
    assign ld2     = {fld[7], fld[6]};
    assign palette = {fld[15], fld[14], fld[13], fld[12], fld[11], fld[10], fld[9], fld[8]};

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = FETCH;
            FETCH:   if (cnt == 5'd15) state_nx = DRAIN;
            DRAIN:   if (cnt == 5'd17) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Address generation, pointer walk, restart bookkeeping and done pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt          <= '0;
            ptr          <= '0;
            addr         <= '0;
            restart_pend <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (restart) ptr <= base_al;
                    if (req) begin
                        // a simultaneous restart must already steer the first address
                        addr <= restart ? base_al : ptr;
                        cnt  <= 5'd1;
                    end
                end
                FETCH: begin
                    addr <= ptr + AW'(cnt[3:0]);
                    cnt  <= cnt + 5'd1;
                    if (restart) restart_pend <= 1'b1;
                end
                DRAIN: begin
                    cnt <= cnt + 5'd1;
                    if (restart) restart_pend <= 1'b1;
                    if (cnt == 5'd17) begin
                        if (restart_pend || restart || reload_flag) ptr <= base_al;
                        else                                        ptr <= ptr + AW'(16);
                        restart_pend <= 1'b0;
                        done         <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Byte capture into the field registers (directly or via the shadow set)
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) fld[i] <= '0;
`ifdef LPT_SHADOW_EN
            for (int i = 0; i < 16; i++) shd[i] <= '0;
`endif
        end else if (cap_en) begin
`ifdef LPT_SHADOW_EN
            shd[cap_idx] <= ram.ram_q;
            if (cnt == 5'd17) begin
                for (int i = 0; i < 15; i++) fld[i] <= shd[i];
                fld[15] <= ram.ram_q;
            end
`else
            fld[cap_idx] <= ram.ram_q;
`endif
        end
    end

endmodule
